// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 instruction-fetch stage: PC register, req/ack imem fetch, halt and error tracking.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] ImmExt,
  input  logic            load,
  output logic            halted,
  output logic            fetch_err
);

  typedef enum logic [2:0] {IDLE, REQ, HOLD, HALT, ERR} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  state_t          state;
  logic [7:0]      wait_cnt;
  logic [7:0]      cnt_inc;
  logic [XLEN-1:0] next_pc;

  assign imem_addr = pc;
  assign pc_plus4  = pc + {{(XLEN-3){1'b0}}, 3'd4};
  assign next_pc   = PCSrc ? (pc + ImmExt) : pc_plus4;
  assign cnt_inc   = wait_cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      halted      <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
          wait_cnt <= '0;
        end
        REQ: begin
          // An ack arriving on the final allowed cycle still wins over the timeout.
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            wait_cnt    <= '0;
            state       <= HOLD;
          end else if (cnt_inc == MAX_CNT) begin
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
            state     <= ERR;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (!load) begin
              halted <= 1'b1;
              state  <= HALT;
            end else if (next_pc[1:0] != 2'b00) begin
              fetch_err <= 1'b1;
              state     <= ERR;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= REQ;
            end
          end
        end
        default: begin
          // HALT and ERR are sticky until reset.
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - Self-checking bench for fetch_unit with a transaction-level PC model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        PCSrc;
  logic [31:0] ImmExt;
  logic        load;
  logic        halted;
  logic        fetch_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
    .pc_plus4(pc_plus4), .PCSrc(PCSrc), .ImmExt(ImmExt), .load(load),
    .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] model_next(input logic src, input logic [31:0] imm);
    return src ? (m_pc + imm) : (m_pc + 32'd4);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; load = 1'b1; PCSrc = 1'b0; ImmExt = '0;
    imem_rdata = '0;
    step(2);
    rst = 1'b0;
    m_pc = 32'h0;
    step(1);
  endtask

  // Waits (bounded) for a request, then acks it on REQ cycle lat with word w.
  task automatic fetch(input int lat, input logic [31:0] w, output bit ok);
    int n = 0;
    while (!imem_req && n < 20) begin
      step(1);
      n++;
    end
    ok = imem_req;
    if (ok) begin
      step(lat - 1);
      imem_ack = 1'b1; imem_rdata = w;
      step(1);
      imem_ack = 1'b0; imem_rdata = $urandom;
    end
  endtask

  task automatic retire(input logic src, input logic [31:0] imm, input logic ld, input int stall);
    instr_ready = 1'b0;
    step(stall);
    PCSrc = src; ImmExt = imm; load = ld; instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0; PCSrc = 1'($urandom); ImmExt = $urandom; load = 1'($urandom);
  endtask

  task automatic test_reset;
    rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; load = 1'b1; PCSrc = 1'b0; ImmExt = '0;
    imem_rdata = '0;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected %h", instr, 32'h0); end
    checks++; if ({instr_valid, imem_req, halted, fetch_err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {instr_valid, imem_req, halted, fetch_err}); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc_plus4: got %h expected %h", pc_plus4, 32'h4); end
    step(2);
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b expected 0", imem_req); end
    step(1);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h expected %h", imem_addr, 32'h0); end
  endtask

  task automatic test_sequential;
    bit ok;
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      w = $urandom | 32'h1;
      checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr: got %h expected %h", imem_addr, 32'(4 * i)); end
      fetch(1, w, ok);
      checks++; if (!ok) begin errors++; $display("FAIL seq_req: got no request expected request"); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid: got %b expected 1", instr_valid); end
      checks++; if (instr !== w) begin errors++; $display("FAIL seq_instr: got %h expected %h", instr, w); end
      retire(1'b0, 32'h0, 1'b1, 0);
      m_pc = model_next(1'b0, 32'h0);
      checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL seq_advance: got valid=%b req=%b expected valid=0 req=1", instr_valid, imem_req); end
    end
  endtask

  task automatic test_random;
    bit ok;
    logic [31:0] w, imm;
    logic        src;
    int          lat;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      w   = $urandom | 32'h1;
      lat = $urandom_range(1, 15);
      checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr: got %h expected %h", imem_addr, m_pc); end
      fetch(lat, w, ok);
      checks++; if (!ok || instr_valid !== 1'b1 || instr !== w) begin errors++; $display("FAIL rnd_fetch: got ok=%b valid=%b instr=%h expected 1 1 %h", ok, instr_valid, instr, w); end
      checks++; if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pc: got %h/%h expected %h/%h", pc, pc_plus4, m_pc, m_pc + 32'd4); end
      src = 1'($urandom);
      imm = 32'($urandom_range(0, 64)) * 32'd4 - 32'd128;
      retire(src, imm, 1'b1, $urandom_range(0, 3));
      m_pc = model_next(src, imm);
      checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin errors++; $display("FAIL rnd_next: got req=%b err=%b expected req=1 err=0", imem_req, fetch_err); end
    end
  endtask

  task automatic test_branch;
    bit ok;
    do_reset();
    fetch(1, 32'h13, ok);
    retire(1'b1, 32'h10, 1'b1, 0);
    m_pc = model_next(1'b1, 32'h10);
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL br_addr10: got %h expected %h", imem_addr, 32'h10); end
    fetch(2, 32'h63, ok);
    retire(1'b1, 32'hFFFF_FFF8, 1'b1, 1);
    m_pc = model_next(1'b1, 32'hFFFF_FFF8);
    checks++; if (imem_addr !== 32'h08 || m_pc !== 32'h08) begin errors++; $display("FAIL br_back: got %h expected %h", imem_addr, 32'h08); end
    fetch(1, 32'h13, ok);
    retire(1'b0, 32'h0, 1'b1, 0);
    fetch(1, 32'h13, ok);
    retire(1'b0, 32'h0, 1'b1, 0);
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL br_addr10b: got %h expected %h", imem_addr, 32'h10); end
    fetch(1, 32'h63, ok);
    retire(1'b1, 32'h6, 1'b1, 0);
    checks++; if (fetch_err !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL br_misalign: got err=%b halted=%b expected err=1 halted=0", fetch_err, halted); end
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL br_misalign_pc: got %h expected %h", pc, 32'h10); end
    step(5);
    checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL br_err_sticky: got err=%b req=%b valid=%b expected 1 0 0", fetch_err, imem_req, instr_valid); end
  endtask

  task automatic test_halt;
    bit ok;
    bit seen_req = 1'b0;
    do_reset();
    fetch(1, 32'h0, ok);
    retire(1'b0, 32'h0, 1'b0, 0);
    checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_enter: got halted=%b valid=%b req=%b expected 1 0 0", halted, instr_valid, imem_req); end
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'($urandom); instr_ready = 1'($urandom); load = 1'($urandom);
      step(1);
      if (imem_req) seen_req = 1'b1;
    end
    imem_ack = 1'b0;
    checks++; if (seen_req !== 1'b0) begin errors++; $display("FAIL halt_no_req: got %b expected 0", seen_req); end
    checks++; if (pc !== 32'h0 || halted !== 1'b1 || fetch_err !== 1'b0) begin errors++; $display("FAIL halt_sticky: got pc=%h halted=%b err=%b expected 0 1 0", pc, halted, fetch_err); end
    rst = 1'b1;
    #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear: got %b expected 0", halted); end
    rst = 1'b0;
  endtask

  task automatic test_timeout;
    bit ok;
    logic [31:0] w = 32'hABCD_0013;
    do_reset();
    step(14);
    checks++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL to_early: got err=%b req=%b expected 0 1", fetch_err, imem_req); end
    step(1);
    checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL to_err: got err=%b req=%b halted=%b expected 1 0 0", fetch_err, imem_req, halted); end
    do_reset();
    fetch(15, w, ok);
    checks++; if (fetch_err !== 1'b0 || instr_valid !== 1'b1 || instr !== w) begin errors++; $display("FAIL to_last_ack: got err=%b valid=%b instr=%h expected 0 1 %h", fetch_err, instr_valid, instr, w); end
  endtask

  task automatic test_stall_wrap;
    bit ok;
    bit bad = 1'b0;
    logic [31:0] w = 32'h0040_0093;
    do_reset();
    fetch(1, w, ok);
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'($urandom); imem_rdata = $urandom;
      step(1);
      if (instr !== w || pc !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b1) bad = 1'b1;
    end
    imem_ack = 1'b0;
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL stall_stable: got %b expected 0", bad); end
    retire(1'b1, 32'hFFFF_FFFC, 1'b1, 0);
    m_pc = model_next(1'b1, 32'hFFFF_FFFC);
    checks++; if (imem_addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_top: got %h/%h expected fffffffc/00000000", imem_addr, pc_plus4); end
    fetch(1, 32'h13, ok);
    retire(1'b0, 32'h0, 1'b1, 0);
    m_pc = model_next(1'b0, 32'h0);
    checks++; if (imem_addr !== m_pc || m_pc !== 32'h0 || imem_req !== 1'b1) begin errors++; $display("FAIL wrap_zero: got addr=%h req=%b expected 0 1", imem_addr, imem_req); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    do_reset();
    step(2);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mid_pre_req: got %b expected 1", imem_req); end
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_req_drop: got %b expected 0", imem_req); end
    step(1);
    rst = 1'b0;
    step(1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL mid_stale_ack: got req=%b addr=%h valid=%b instr=%h expected 1 0 0 0", imem_req, imem_addr, instr_valid, instr); end
    imem_ack = 1'b0;
    fetch(3, 32'h0000_0513, ok);
    checks++; if (instr !== 32'h0000_0513 || instr_valid !== 1'b1) begin errors++; $display("FAIL mid_refetch: got %h valid=%b expected 00000513 1", instr, instr_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_random();
    test_branch();
    test_halt();
    test_timeout();
    test_stall_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the control unit in the single-cycle RV32 core. It owns the PC register and fetches from instruction memory using a variable-latency req/ack handshake. It holds each fetched instruction stable for the decode/execute path, then advances the PC using the control unit's PCSrc and load outputs. It halts permanently on an all-zero opcode and flags fetch errors.

Parameters:
XLEN, 32, width of PC, addresses and immediates
RESET_PC, 32'h0000_0000, PC value loaded on reset
MAX_WAIT, 15, number of REQ-state cycles without imem_ack before a timeout error (1..255)

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  XLEN  fetch address; equals pc
imem_ack  input  1  instruction memory response valid; imem_rdata is sampled on this cycle
imem_rdata  input  32  fetched instruction word
instr  output  32  registered instruction to the decode/control unit
instr_valid  output  1  instr is valid and stable
instr_ready  input  1  downstream has completed the instruction; the PC may advance
pc  output  XLEN  address of the current instruction
pc_plus4  output  XLEN  pc + 4, modulo 2^XLEN
PCSrc  input  1  branch taken, from the control unit
ImmExt  input  XLEN  sign-extended branch offset
load  input  1  from the control unit; 0 means an all-zero opcode, so halt
halted  output  1  sticky halt indicator
fetch_err  output  1  sticky error indicator (timeout or misaligned target)

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - pc=RESET_PC; instr=0; instr_valid=0; imem_req=0; halted=0; fetch_err=0; wait counter=0; state=IDLE.
  - If reset arrives during an outstanding request, imem_req drops in the same cycle. A late imem_ack after reset is ignored.
- States: IDLE, REQ, HOLD, HALT, ERR.
- IDLE: lasts one cycle after reset deassert, then goes to REQ.
- REQ:
  - imem_req=1 and imem_addr=pc. The wait counter increments each cycle.
  - On imem_ack=1: capture instr<=imem_rdata, clear the counter, go to HOLD. instr_valid becomes 1 on the next cycle, so latency is ack cycle N to instr_valid at N+1.
  - If the counter reaches MAX_WAIT with imem_ack=0: go to ERR.
  - If ack and counter==MAX_WAIT occur in the same cycle, the ack wins.
- HOLD:
  - imem_req=0, instr_valid=1. instr and pc are stable; PCSrc, ImmExt and load are only meaningful here.
  - On instr_ready=1 with load=0: go to HALT; pc is unchanged.
  - On instr_ready=1 with load=1:
    - Compute next = PCSrc ? pc+ImmExt : pc+4, with the sum truncated to XLEN (wrap-around allowed; 32'hFFFF_FFFC+4 → 0).
    - If next[1:0]!=0, go to ERR and leave pc unchanged.
    - Otherwise pc<=next, then go to REQ. instr_valid falls in the same edge.
  - If instr_ready=0, stay in HOLD indefinitely.
- HALT: halted=1, instr_valid=0, imem_req=0. Sticky until reset.
- ERR: fetch_err=1, instr_valid=0, imem_req=0. Sticky until reset. halted stays 0.
- pc_plus4 is combinational from pc at all times.
- imem_ack outside REQ is ignored.
- Throughput: with single-cycle ack, one instruction per 2 cycles plus the instr_ready wait.

Test Plan:
- Reset then sequential fetch: RESET_PC=0, ack 1 cycle after each req, instr_ready=1 in HOLD, load=1, PCSrc=0 → imem_addr sequence 0x0, 0x4, 0x8; instr_valid rises the cycle after each ack; instr matches each word.
- Taken branch: pc=0x10, PCSrc=1, ImmExt=0xFFFF_FFF8 → next imem_addr=0x08. With ImmExt=0x6 → fetch_err=1, pc stays 0x10.
- Halt: instruction 0x0000_0000 fetched, load=0 and instr_ready=1 → halted=1 on the next edge; no further imem_req; pc frozen. Clears only on rst.
- Timeout: MAX_WAIT=15, ack never asserted → fetch_err=1 after 15 REQ cycles. Repeat with ack on exactly the 15th cycle → instruction accepted, no error.
- Stall/wrap: instr_ready held 0 for 10 cycles → instr and pc stable, no req. Then pc=0xFFFF_FFFC with PCSrc=0 → next imem_addr=0x0.
- Reset mid-request: assert rst while imem_req=1 → imem_req=0 immediately; after release, IDLE→REQ at RESET_PC; stale ack ignored.
